// File: rtl/mult_rr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_rr_sequencer_pkg
// Description : Shared definitions for the two-requester shift-add multiplier
//               sequencer. Holds the state encoding and the requester IDs.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_rr_sequencer_pkg;

    // State encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_ADD   = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_LOAD  = c_ST_LOAD,
        ST_ADD   = c_ST_ADD,
        ST_SHIFT = c_ST_SHIFT,
        ST_DONE  = c_ST_DONE
    } state_t;

    // Requester identifiers
    localparam logic c_REQ0 = 1'b0;
    localparam logic c_REQ1 = 1'b1;

endpackage : mult_rr_sequencer_pkg
`default_nettype wire

// File: rtl/mult_rr_sequencer_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin picker. When both inputs
//               are eligible the pointer decides; otherwise the single
//               eligible requester wins. The pointer register lives in the
//               parent.
// Ports       : eligible[1:0] - eligible requesters
//               ptr           - preferred requester on a tie
//               valid         - at least one requester eligible
//               winner        - selected requester ID (meaningful if valid)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       ptr,
    output logic       valid,
    output logic       winner
);
    import mult_rr_sequencer_pkg::*;

    always_comb begin
        valid  = |eligible;
        winner = c_REQ0;
        if (&eligible) begin
            winner = ptr;
        end else if (eligible[1]) begin
            winner = c_REQ1;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mult_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_rr_sequencer
// Description : Round-robin controller sharing one shift-add SIZE x SIZE
//               multiplier datapath between two requesters. Latches the
//               winner's ROM addresses, sequences LOAD / ADD / SHIFT, then
//               captures the product and pulses done for the owner.
// Ports       : clk            - system clock (5 MHz domain)
//               reset          - asynchronous active-low reset
//               req[1:0]       - level requests
//               mcand_addrN    - multiplicand ROM address of requester N
//               mplier_addrN   - multiplier ROM address of requester N
//               lsb            - accumulator bit 0
//               count_done     - datapath counter == SIZE-1
//               product        - accumulator product bits
//               dp_load/add/shift/cnt_up - datapath strobes
//               m_sel, rom_addr - ROM half select and full ROM address
//               grant, done    - per-requester one-cycle pulses
//               result         - last completed product
//               busy, owner    - activity flag and current/last owner
// Revision    : 1.0 - initial release
// ============================================================================
module mult_rr_sequencer #(
    parameter int SIZE   = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [ADDR_W-1:0]   mcand_addr0,
    input  logic [ADDR_W-1:0]   mplier_addr0,
    input  logic [ADDR_W-1:0]   mcand_addr1,
    input  logic [ADDR_W-1:0]   mplier_addr1,
    input  logic                lsb,
    input  logic                count_done,
    input  logic [2*SIZE-1:0]   product,
    output logic                dp_load,
    output logic                add,
    output logic                shift,
    output logic                cnt_up,
    output logic                m_sel,
    output logic [ADDR_W:0]     rom_addr,
    output logic [1:0]          grant,
    output logic [1:0]          done,
    output logic [2*SIZE-1:0]   result,
    output logic                busy,
    output logic                owner
);
    import mult_rr_sequencer_pkg::*;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_ptr;
    logic [ADDR_W-1:0]   r_mcand;
    logic [ADDR_W-1:0]   r_mplier;
    logic [1:0]          r_done;
    logic [2*SIZE-1:0]   r_result;

    logic [1:0]          w_eligible;
    logic                w_pick;
    logic                w_winner;
    logic [1:0]          w_grant;

    // A requester is masked during its own done cycle so a still-high
    // req is not mistaken for a new job.
    assign w_eligible = req & ~r_done;

    rr_arb2 u_arb (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .valid    (w_pick),
        .winner   (w_winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= c_REQ0;
            r_ptr    <= c_REQ0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_done   <= 2'b00;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 2'b00;
            if (r_state == ST_IDLE && w_pick) begin
                r_owner  <= w_winner;
                r_mcand  <= w_winner ? mcand_addr1  : mcand_addr0;
                r_mplier <= w_winner ? mplier_addr1 : mplier_addr0;
            end
            if (r_state == ST_DONE) begin
                r_result         <= product;
                r_done[r_owner]  <= 1'b1;
                r_ptr            <= ~r_owner;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dp_load     = 1'b0;
        add         = 1'b0;
        shift       = 1'b0;
        cnt_up      = 1'b0;
        m_sel       = 1'b0;
        w_grant     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_pick) begin
                    w_grant[w_winner] = 1'b1;
                    w_state_nxt       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dp_load     = 1'b1;
                m_sel       = 1'b1;
                w_state_nxt = ST_ADD;
            end
            ST_ADD: begin
                add         = lsb;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift       = 1'b1;
                cnt_up      = 1'b1;
                w_state_nxt = count_done ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // grant is decoded from live req; force it low while reset is held so
    // every output reads zero during reset.
    always_comb begin
        grant    = w_grant & {2{reset}};
        rom_addr = {m_sel, (m_sel ? r_mplier : r_mcand)};
        busy     = (r_state != ST_IDLE);
        owner    = r_owner;
        done     = r_done;
        result   = r_result;
    end

endmodule : mult_rr_sequencer
`default_nettype wire

// File: tb/tb_mult_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_rr_sequencer
// Description : Directed self-checking bench for mult_rr_sequencer with a
//               behavioural shift-add datapath whose ROM returns its address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_rr_sequencer;
    localparam int SIZE   = 4;
    localparam int ADDR_W = 4;

    logic                clk;
    logic                reset;
    logic [1:0]          req;
    logic [ADDR_W-1:0]   mcand_addr0, mplier_addr0, mcand_addr1, mplier_addr1;
    logic                lsb, count_done;
    logic [2*SIZE-1:0]   product;
    logic                dp_load, add, shift, cnt_up, m_sel, busy, owner;
    logic [ADDR_W:0]     rom_addr;
    logic [1:0]          grant, done;
    logic [2*SIZE-1:0]   result;

    mult_rr_sequencer #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req),
        .mcand_addr0(mcand_addr0), .mplier_addr0(mplier_addr0),
        .mcand_addr1(mcand_addr1), .mplier_addr1(mplier_addr1),
        .lsb(lsb), .count_done(count_done), .product(product),
        .dp_load(dp_load), .add(add), .shift(shift), .cnt_up(cnt_up),
        .m_sel(m_sel), .rom_addr(rom_addr), .grant(grant), .done(done),
        .result(result), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: accumulator carries one extra bit for the add carry.
    logic [2*SIZE:0]   m_acc = '0;
    int                m_cnt = 0;
    logic [SIZE-1:0]   w_rom_data;
    assign w_rom_data = rom_addr[ADDR_W-1:0];
    assign lsb        = m_acc[0];
    assign count_done = (m_cnt == SIZE-1);
    assign product    = m_acc[2*SIZE-1:0];

    always @(posedge clk) begin
        if (dp_load) begin
            m_acc <= {{(SIZE+1){1'b0}}, w_rom_data};
            m_cnt <= 0;
        end else begin
            if (add)    m_acc[2*SIZE:SIZE] <= m_acc[2*SIZE:SIZE] + {1'b0, w_rom_data};
            if (shift)  m_acc <= m_acc >> 1;
            if (cnt_up) m_cnt <= m_cnt + 1;
        end
    end

    // Cycle counter and event monitor (samples mid-cycle on negedge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_add = 0, n_shift = 0, n_cnt = 0, n_self = 0, n_done1 = 0, ng = 0;
    int glog [0:63];
    always @(negedge clk) begin
        if (add)    n_add++;
        if (shift)  n_shift++;
        if (cnt_up) n_cnt++;
        if ((grant & done) != 2'b00) n_self++;
        if (done[1]) n_done1++;
        if (grant != 2'b00 && ng < 64) begin
            glog[ng] = grant[1] ? 1 : 0;
            ng++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 2'b00;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic wait_done(output logic found);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int   c0, c1, s_add, s_sh, s_cnt, ng0, self0, d1_0;
    logic found;
    logic [3:0] obs_add;

    initial begin
        reset = 1'b0;
        req   = 2'b00;
        mcand_addr0 = '0; mplier_addr0 = '0; mcand_addr1 = '0; mplier_addr1 = '0;
        #12;
        check("reset_outputs",
              {dp_load, add, shift, cnt_up, m_sel, grant, done, busy, owner, result, rom_addr},
              32'h0);
        drive_edge();
        reset = 1'b1;

        // ---- Job 7x5 for requester 0; operands changed right after grant ----
        drive_edge();
        mcand_addr0 = 4'd7; mplier_addr0 = 4'd5; req = 2'b01;
        s_sh = n_shift; s_cnt = n_cnt;
        tick();
        check("t1_grant0", grant, 2'b01);
        check("t1_busy_idle", busy, 1'b0);
        drive_edge();
        req = 2'b00; mcand_addr0 = 4'd2; mplier_addr0 = 4'd2;
        tick();
        check("t1_dp_load", dp_load, 1'b1);
        check("t1_rom_mplier", rom_addr, 5'h15);
        obs_add = 4'b0000;
        for (int k = 2; k <= 11; k++) begin
            tick();
            if (k == 2) check("t1_rom_mcand", rom_addr, 5'h07);
            if (k % 2 == 0 && k <= 8) obs_add[(k-2)/2] = add;
            if (k == 10) check("t1_no_early_done", done, 2'b00);
        end
        check("t1_add_pattern", obs_add, 4'b0101);
        check("t1_done0", done, 2'b01);
        check("t1_result", result, 8'h23);
        check("t1_busy_low", busy, 1'b0);
        check("t1_shifts", n_shift - s_sh, 4);
        check("t1_cnt_ups", n_cnt - s_cnt, 4);
        tick();
        check("t1_done_pulse_one_cycle", done, 2'b00);
        check("t1_result_held", result, 8'h23);

        // ---- Simultaneous requests: 15x15 then 3x0 ----
        do_reset();
        mcand_addr0 = 4'd15; mplier_addr0 = 4'd15; mcand_addr1 = 4'd3; mplier_addr1 = 4'd0;
        s_add = n_add; s_sh = n_shift; s_cnt = n_cnt;
        drive_edge();
        req = 2'b11;
        tick();
        c0 = cyc;
        check("t2_grant0_first", grant, 2'b01);
        wait_done(found);
        check("t2_done0_seen", found, 1'b1);
        check("t2_latency0", cyc - c0, 11);
        check("t2_done0", done, 2'b01);
        check("t2_result0", result, 8'hE1);
        check("t2_grant1_in_done0", grant, 2'b10);
        check("t2_adds_15x15", n_add - s_add, 4);
        check("t2_shifts_15x15", n_shift - s_sh, 4);
        check("t2_cnt_15x15", n_cnt - s_cnt, 4);
        c1 = cyc; s_add = n_add; s_sh = n_shift;
        drive_edge();
        req = 2'b00;
        tick();
        check("t2_owner1", owner, 1'b1);
        wait_done(found);
        check("t2_done1_seen", found, 1'b1);
        check("t2_latency1", cyc - c1, 11);
        check("t2_done1", done, 2'b10);
        check("t2_result1", result, 8'h00);
        check("t2_no_adds_mplier0", n_add - s_add, 0);
        check("t2_shifts_mplier0", n_shift - s_sh, 4);

        // ---- Both requests held for four jobs ----
        do_reset();
        mcand_addr0 = 4'd3; mplier_addr0 = 4'd2; mcand_addr1 = 4'd1; mplier_addr1 = 4'd1;
        ng0 = ng; self0 = n_self;
        drive_edge();
        req = 2'b11;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (ng - ng0 >= 4) break;
        end
        check("t3_four_grants", ng - ng0, 4);
        drive_edge();
        req = 2'b00;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (!busy) break;
        end
        check("t3_final_done", done, 2'b10);
        check("t3_final_result", result, 8'h01);
        check("t3_order", {glog[ng0][0], glog[ng0+1][0], glog[ng0+2][0], glog[ng0+3][0]}, 4'b0101);
        check("t3_no_self_grant", n_self - self0, 0);

        // ---- Reset during the second SHIFT of a requester-1 job ----
        do_reset();
        mcand_addr1 = 4'd3; mplier_addr1 = 4'd3; mcand_addr0 = 4'd6; mplier_addr0 = 4'd3;
        drive_edge();
        req = 2'b10;
        tick();
        check("t5_grant1", grant, 2'b10);
        d1_0 = n_done1;
        repeat (5) tick();
        check("t5_in_second_shift", shift, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_outputs_cleared",
              {dp_load, add, shift, cnt_up, m_sel, grant, done, busy, owner, result, rom_addr},
              32'h0);
        req = 2'b11;
        drive_edge();
        reset = 1'b1;
        tick();
        check("t5_grant0_after_reset", grant, 2'b01);
        drive_edge();
        req = 2'b00;
        wait_done(found);
        check("t5_done_seen", found, 1'b1);
        check("t5_done0", done, 2'b01);
        check("t5_result", result, 8'h12);
        check("t5_no_abandoned_done", n_done1 - d1_0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mult_rr_sequencer
`default_nettype wire
